// File: rtl/box_overlay_pkg.sv
// Shared definitions for the box overlay: RGB565 colours and
// helpers that unpack the {max, min} coordinate words.
package box_overlay_pkg;

    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_BLACK = 16'h0000;

    localparam int CNT_W = 4;

    function automatic logic [15:0] coor_min(input logic [31:0] c);
        return c[15:0];
    endfunction

    function automatic logic [15:0] coor_max(input logic [31:0] c);
        return c[31:16];
    endfunction

endpackage

// File: rtl/box_hit_cmp.sv
// One stored box against the current pixel position: true when the
// pixel lies inside the box and within THICK pixels of its outline.
module box_hit_cmp
    import box_overlay_pkg::*;
#(
    parameter int CW    = 16,
    parameter int THICK = 2
) (
    input  logic [CW-1:0] x,
    input  logic [CW-1:0] y,
    input  logic [CW-1:0] x_min,
    input  logic [CW-1:0] x_max,
    input  logic [CW-1:0] y_min,
    input  logic [CW-1:0] y_max,
    output logic          hit
);

    localparam logic [CW:0] TK = (CW+1)'(THICK);

    logic [CW:0] xe, ye, x0, x1, y0, y1;
    logic        inx, iny, edge_x, edge_y;

    assign xe = {1'b0, x};
    assign ye = {1'b0, y};
    assign x0 = {1'b0, x_min};
    assign x1 = {1'b0, x_max};
    assign y0 = {1'b0, y_min};
    assign y1 = {1'b0, y_max};

    assign inx = (x0 <= xe) && (xe <= x1);
    assign iny = (y0 <= ye) && (ye <= y1);

    // x > x_max-THICK rewritten as x+THICK > x_max so nothing wraps
    assign edge_x = (xe < x0 + TK) || (xe + TK > x1);
    assign edge_y = (ye < y0 + TK) || (ye + TK > y1);

    assign hit = inx && iny && (edge_x || edge_y);

endmodule

// File: rtl/box_overlay.sv
// Captures box reports during frame N into a shadow bank and draws
// their outlines onto the RGB565 stream of frame N+1.
module box_overlay
    import box_overlay_pkg::*;
#(
    parameter int          MAX_BOX   = 4,
    parameter int          THICK     = 2,
    parameter logic [15:0] BOX_COLOR = RGB565_RED,
    parameter int          CW        = 16
) (
    input  logic             sclk,
    input  logic             s_rst,
    input  logic             vsync_i,
    input  logic             hsync_i,
    input  logic             data_en_i,
    input  logic [15:0]      data_i,
    input  logic             overlay_en,
    input  logic             coor_valid_flag,
    input  logic [15:0]      valid_num,
    input  logic [31:0]      x_coor,
    input  logic [31:0]      y_coor,
    output logic             vsync_o,
    output logic             hsync_o,
    output logic             data_en_o,
    output logic [15:0]      data_o,
    output logic [CNT_W-1:0] box_cnt_o,
    output logic             ovf_o
);

    logic          vs_q, de_q;
    logic          vs_rise, de_fall;
    logic [CW-1:0] x_cnt, y_cnt;

    assign vs_rise = vsync_i && !vs_q;
    assign de_fall = de_q && !data_en_i;

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            vs_q  <= 1'b0;
            de_q  <= 1'b0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            vs_q <= vsync_i;
            de_q <= data_en_i;
            if (vs_rise) begin
                x_cnt <= '0;
                y_cnt <= '0;
            end else if (de_fall) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 1'b1;
            end else if (data_en_i) begin
                x_cnt <= x_cnt + 1'b1;
            end
        end
    end

    logic [15:0]   xl_f, xh_f, yl_f, yh_f;
    logic [CW-1:0] rx0, rx1, ry0, ry1;
    logic          accept;

    assign xl_f = coor_min(x_coor);
    assign xh_f = coor_max(x_coor);
    assign yl_f = coor_min(y_coor);
    assign yh_f = coor_max(y_coor);
    assign rx0  = xl_f[CW-1:0];
    assign rx1  = xh_f[CW-1:0];
    assign ry0  = yl_f[CW-1:0];
    assign ry1  = yh_f[CW-1:0];

    assign accept = coor_valid_flag && (valid_num != 16'd0)
                 && (rx0 <= rx1) && (ry0 <= ry1);

    logic [CW-1:0]    shd_x0 [MAX_BOX];
    logic [CW-1:0]    shd_x1 [MAX_BOX];
    logic [CW-1:0]    shd_y0 [MAX_BOX];
    logic [CW-1:0]    shd_y1 [MAX_BOX];
    logic [CW-1:0]    act_x0 [MAX_BOX];
    logic [CW-1:0]    act_x1 [MAX_BOX];
    logic [CW-1:0]    act_y0 [MAX_BOX];
    logic [CW-1:0]    act_y1 [MAX_BOX];
    logic [CNT_W-1:0] shd_cnt;
    logic             shd_ovf;

    // Swap wins over a coinciding strobe, which lands in the new slot 0
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            shd_cnt   <= '0;
            shd_ovf   <= 1'b0;
            box_cnt_o <= '0;
            ovf_o     <= 1'b0;
        end else if (vs_rise) begin
            for (int i = 0; i < MAX_BOX; i++) begin
                act_x0[i] <= shd_x0[i];
                act_x1[i] <= shd_x1[i];
                act_y0[i] <= shd_y0[i];
                act_y1[i] <= shd_y1[i];
            end
            box_cnt_o <= shd_cnt;
            ovf_o     <= shd_ovf;
            shd_ovf   <= 1'b0;
            if (accept) begin
                shd_x0[0] <= rx0;
                shd_x1[0] <= rx1;
                shd_y0[0] <= ry0;
                shd_y1[0] <= ry1;
                shd_cnt   <= CNT_W'(1);
            end else begin
                shd_cnt <= '0;
            end
        end else if (accept) begin
            if (shd_cnt == CNT_W'(MAX_BOX)) begin
                shd_ovf <= 1'b1;
            end else begin
                for (int i = 0; i < MAX_BOX; i++) begin
                    if (shd_cnt == CNT_W'(i)) begin
                        shd_x0[i] <= rx0;
                        shd_x1[i] <= rx1;
                        shd_y0[i] <= ry0;
                        shd_y1[i] <= ry1;
                    end
                end
                shd_cnt <= shd_cnt + 1'b1;
            end
        end
    end

    logic [MAX_BOX-1:0] hit_raw, hit_c;

    for (genvar g = 0; g < MAX_BOX; g++) begin : g_cmp
        box_hit_cmp #(
            .CW    (CW),
            .THICK (THICK)
        ) u_cmp (
            .x     (x_cnt),
            .y     (y_cnt),
            .x_min (act_x0[g]),
            .x_max (act_x1[g]),
            .y_min (act_y0[g]),
            .y_max (act_y1[g]),
            .hit   (hit_raw[g])
        );
        assign hit_c[g] = hit_raw[g] && (CNT_W'(g) < box_cnt_o);
    end

    logic               vs1, hs1, de1, ov1;
    logic [15:0]        d1;
    logic [MAX_BOX-1:0] hit1;

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            vs1       <= 1'b0;
            hs1       <= 1'b0;
            de1       <= 1'b0;
            ov1       <= 1'b0;
            d1        <= '0;
            hit1      <= '0;
            vsync_o   <= 1'b0;
            hsync_o   <= 1'b0;
            data_en_o <= 1'b0;
            data_o    <= '0;
        end else begin
            vs1       <= vsync_i;
            hs1       <= hsync_i;
            de1       <= data_en_i;
            ov1       <= overlay_en;
            d1        <= data_i;
            hit1      <= hit_c;
            vsync_o   <= vs1;
            hsync_o   <= hs1;
            data_en_o <= de1;
            if (!de1)
                data_o <= '0;
            else if (ov1 && |hit1)
                data_o <= BOX_COLOR;
            else
                data_o <= d1;
        end
    end

endmodule

// File: tb/tb_box_overlay.sv
// Directed-frame bench for box_overlay: a box-list model predicts every
// output cycle, and literal probes pin a few pixels by hand.
module tb_box_overlay;

    localparam int          MAXB = 4;
    localparam int          TK   = 1;
    localparam logic [15:0] COL  = 16'hF800;
    localparam int          W    = 64;
    localparam int          H    = 16;

    logic        sclk = 1'b0;
    logic        s_rst = 1'b1;
    logic        vsync_i = 1'b0, hsync_i = 1'b0, data_en_i = 1'b0;
    logic [15:0] data_i = '0;
    logic        overlay_en = 1'b1;
    logic        coor_valid_flag = 1'b0;
    logic [15:0] valid_num = '0;
    logic [31:0] x_coor = '0, y_coor = '0;
    logic        vsync_o, hsync_o, data_en_o, ovf_o;
    logic [15:0] data_o;
    logic [3:0]  box_cnt_o;

    always #5 sclk = ~sclk;

    box_overlay #(
        .MAX_BOX   (MAXB),
        .THICK     (TK),
        .BOX_COLOR (COL),
        .CW        (16)
    ) dut (
        .sclk            (sclk),
        .s_rst           (s_rst),
        .vsync_i         (vsync_i),
        .hsync_i         (hsync_i),
        .data_en_i       (data_en_i),
        .data_i          (data_i),
        .overlay_en      (overlay_en),
        .coor_valid_flag (coor_valid_flag),
        .valid_num       (valid_num),
        .x_coor          (x_coor),
        .y_coor          (y_coor),
        .vsync_o         (vsync_o),
        .hsync_o         (hsync_o),
        .data_en_o       (data_en_o),
        .data_o          (data_o),
        .box_cnt_o       (box_cnt_o),
        .ovf_o           (ovf_o)
    );

    typedef struct {int x0; int x1; int y0; int y1; int vn;} bx_t;
    typedef struct packed {
        logic vs; logic hs; logic de; logic [15:0] d;
        logic [3:0] cnt; logic ovf; logic [7:0] x; logic [7:0] y;
    } ex_t;

    bx_t act[$], shd[$], rep_q[$];
    bx_t nob = '{0, 0, 0, 0, 0};
    int  m_cnt = 0;
    bit  m_ovf = 0, m_ovf_shd = 0, prev_vs = 0;

    ex_t ex_cur = '0, e1 = '0, e2 = '0;
    int  errors = 0, checks = 0;
    bit  run = 0;
    int  px[4] = '{10, 15, 15, 42};
    int  py[4] = '{6, 5, 6, 8};
    logic [15:0] grab[4];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] pat(input int x, input int y);
        return 16'(32'h0421 + y * 256 + x);
    endfunction

    function automatic logic [15:0] pix(input int x, input int y,
                                        input logic [15:0] d, input bit ov);
        if (!ov) return d;
        foreach (act[i]) begin
            if (x >= act[i].x0 && x <= act[i].x1 &&
                y >= act[i].y0 && y <= act[i].y1 &&
                (x < act[i].x0 + TK || x > act[i].x1 - TK ||
                 y < act[i].y0 + TK || y > act[i].y1 - TK))
                return COL;
        end
        return d;
    endfunction

    task automatic step(input bit vs, input bit hs, input bit de,
                        input logic [15:0] d, input int x, input int y,
                        input bit stb, input bx_t b);
        vsync_i         = vs;
        hsync_i         = hs;
        data_en_i       = de;
        data_i          = d;
        coor_valid_flag = stb;
        valid_num       = 16'(b.vn);
        x_coor          = {16'(b.x1), 16'(b.x0)};
        y_coor          = {16'(b.y1), 16'(b.y0)};
        ex_cur.vs = vs;
        ex_cur.hs = hs;
        ex_cur.de = de;
        ex_cur.d  = de ? pix(x, y, d, overlay_en) : 16'h0;
        ex_cur.x  = 8'(x);
        ex_cur.y  = 8'(y);
        if (vs && !prev_vs) begin
            act = shd;
            m_cnt = shd.size();
            m_ovf = m_ovf_shd;
            shd.delete();
            m_ovf_shd = 0;
        end
        prev_vs = vs;
        if (stb && b.vn != 0 && b.x0 <= b.x1 && b.y0 <= b.y1) begin
            if (shd.size() == MAXB) m_ovf_shd = 1;
            else shd.push_back(b);
        end
        ex_cur.cnt = 4'(m_cnt);
        ex_cur.ovf = m_ovf;
        @(posedge sclk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 16'h0, 0, 0, 0, nob);
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        act.delete();
        shd.delete();
        m_cnt = 0;
        m_ovf = 0;
        m_ovf_shd = 0;
        idle();
        idle();
        chk("rst_data", data_o, 0);
        chk("rst_de", data_en_o, 0);
        chk("rst_vs", vsync_o, 0);
        chk("rst_cnt", box_cnt_o, 0);
        chk("rst_ovf", ovf_o, 0);
        idle();
        s_rst = 1'b0;
    endtask

    task automatic frame(input bit sv, input bx_t vb, input int rst_line);
        step(1, 0, 0, 16'h0, 0, 0, sv, vb);
        step(1, 0, 0, 16'h0, 0, 0, 0, nob);
        idle();
        idle();
        for (int y = 0; y < H; y++) begin
            step(0, 1, 0, 16'h0, 0, 0, 0, nob);
            step(0, 1, 0, 16'h0, 0, 0, 0, nob);
            idle();
            if (rep_q.size() > 0) begin
                bx_t r;
                r = rep_q.pop_front();
                step(0, 0, 0, 16'h0, 0, 0, 1, r);
            end else begin
                idle();
            end
            for (int x = 0; x < W; x++)
                step(0, 0, 1, pat(x, y), x, y, 0, nob);
            idle();
            idle();
            if (y == rst_line) do_reset();
        end
    endtask

    always @(posedge sclk) begin
        if (s_rst) begin
            e1 <= '0;
            e2 <= '0;
        end else begin
            e1 <= ex_cur;
            e2 <= e1;
        end
    end

    always @(negedge sclk) begin
        if (run) begin
            chk("vsync_o", vsync_o, e2.vs);
            chk("hsync_o", hsync_o, e2.hs);
            chk("data_en_o", data_en_o, e2.de);
            chk("data_o", data_o, e2.d);
            chk("box_cnt_o", box_cnt_o, e1.cnt);
            chk("ovf_o", ovf_o, e1.ovf);
            for (int k = 0; k < 4; k++)
                if (e2.de && e2.x == 8'(px[k]) && e2.y == 8'(py[k]))
                    grab[k] = data_o;
        end
    end

    initial begin
        bx_t ba, bb, bc, bd, be;
        ba = '{10, 20, 5, 8, 1};
        bb = '{30, 40, 0, 3, 2};
        bc = '{0, 3, 10, 12, 3};
        bd = '{50, 63, 12, 15, 4};
        be = '{40, 45, 8, 9, 5};
        repeat (3) @(posedge sclk);
        #1;
        chk("reset_data", data_o, 0);
        chk("reset_cnt", box_cnt_o, 0);
        chk("reset_ovf", ovf_o, 0);
        s_rst = 1'b0;
        run = 1;

        rep_q.push_back(ba);
        frame(0, nob, -1);
        chk("f0_unmodified", grab[0], 16'h0A2B);

        frame(0, nob, -1);
        chk("f1_cnt", box_cnt_o, 1);
        chk("f1_px10_6", grab[0], 16'hF800);
        chk("f1_px15_5", grab[1], 16'hF800);
        chk("f1_px15_6", grab[2], 16'h0A30);

        rep_q.push_back(ba);
        rep_q.push_back(bb);
        rep_q.push_back(bc);
        rep_q.push_back(bd);
        rep_q.push_back(be);
        frame(0, nob, -1);
        chk("f2_cnt", box_cnt_o, 0);

        rep_q.push_back('{30, 20, 1, 4, 1});
        rep_q.push_back('{1, 5, 1, 5, 0});
        frame(0, nob, -1);
        chk("ovf_cnt", box_cnt_o, 4);
        chk("ovf_flag", ovf_o, 1);
        chk("fifth_absent", grab[3], 16'h0C4B);
        chk("ovf_px10_6", grab[0], 16'hF800);

        frame(0, nob, -1);
        chk("drop_cnt", box_cnt_o, 0);
        chk("drop_ovf", ovf_o, 0);

        frame(1, ba, -1);
        chk("vs_strobe_cnt", box_cnt_o, 0);
        chk("vs_strobe_absent", grab[0], 16'h0A2B);

        rep_q.push_back(ba);
        rep_q.push_back(bb);
        frame(0, nob, -1);
        chk("vs_strobe_cnt2", box_cnt_o, 1);
        chk("vs_strobe_drawn", grab[0], 16'hF800);

        overlay_en = 1'b0;
        frame(0, nob, -1);
        chk("pass_cnt", box_cnt_o, 2);
        chk("pass_px10_6", grab[0], 16'h0A2B);
        overlay_en = 1'b1;

        rep_q.push_back(ba);
        rep_q.push_back(bb);
        frame(0, nob, 5);
        frame(0, nob, -1);
        chk("post_rst_cnt", box_cnt_o, 0);
        chk("post_rst_px", grab[0], 16'h0A2B);

        idle();
        idle();
        idle();
        run = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
